dmem_ctrl: RTL and testbench

- Parametrised data memory for the pipeline's MEM stage, the successor to the fixed 32-word data memory.
- Adds a valid/ready request/response handshake and byte/half/word access with byte enables and load sign/zero extension.
- Detects misaligned and out-of-range accesses, and can clear its contents after reset with an internal state machine.
- Sits between the MEM-stage pipeline register and the MEM/WB register; the pipeline stalls while req_ready=0.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_lane_align.sv | 46 ++++
 rtl/dmem_ctrl.sv | 104 ++++++++++
 tb/tb_dmem_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  // Alignment fault for the legal sizes; the illegal size code is flagged separately.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data and
// load extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  input  logic        zero_ext,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Decode size/lane into enables, positioned store data and extended load data.
  always_comb begin
    be         = '0;
    wdata_lane = '0;
    rdata_ext  = '0;
    rbyte      = rword[{addr_lo, 3'b000} +: 8];
    rhalf      = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{rbyte[7] & ~zero_ext}}, rbyte};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{rhalf[15] & ~zero_ext}}, rhalf};
      end
      SZ_WORD: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Parametrised data memory with valid/ready request/response handshake,
// sub-word access, error detection and optional clear-after-reset.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

  logic [31:0]       mem [DEPTH];
  state_t            state;
  logic [IDX_W-1:0]  cnt;

  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              err;
  logic              accept;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic [31:0]       rext;

  assign word_idx  = req_addr[ADDR_W-1:2];
  assign idx       = word_idx[IDX_W-1:0];
  assign in_range  = (word_idx < DEPTH_IDX);
  assign err       = (req_size == 2'b11) || is_misaligned(req_size, req_addr[1:0]) || !in_range;
  assign busy      = (state == ST_INIT);
  // One-entry response buffer: a new request may enter as the old response leaves.
  assign req_ready = (state == ST_RUN) && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;
  assign rword     = in_range ? mem[idx] : '0;

  dmem_lane_align u_align (
    .size       (req_size),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .rword      (rword),
    .zero_ext   (req_unsigned),
    .be         (be),
    .wdata_lane (wlane),
    .rdata_ext  (rext)
  );

  // Storage: clear sweep during INIT, byte-enabled store on a clean accept; nothing on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[cnt] <= '0;
      end else if (accept && req_we && !err) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
        end
      end
    end
  end

  // FSM, init counter and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) state <= ST_RUN;
        end
        default: ;
      endcase
      if (accept) begin
        resp_valid <= 1'b1;
        resp_err   <= err;
        resp_rdata <= (err || req_we) ? '0 : rext;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: byte-level reference model, decoupled monitor.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_ready, req_we, req_unsigned;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [1:0]  req_size;

  logic        k_rst, k_req_valid, k_req_ready, k_req_we, k_req_unsigned;
  logic        k_resp_valid, k_resp_ready, k_resp_err, k_busy;
  logic [31:0] k_req_addr, k_req_wdata, k_resp_rdata;
  logic [1:0]  k_req_size;

  dmem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  dmem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b0)) dut_keep (
    .clk(clk), .rst(k_rst), .req_valid(k_req_valid), .req_ready(k_req_ready), .req_we(k_req_we),
    .req_addr(k_req_addr), .req_wdata(k_req_wdata), .req_size(k_req_size),
    .req_unsigned(k_req_unsigned), .resp_valid(k_resp_valid), .resp_ready(k_resp_ready),
    .resp_rdata(k_resp_rdata), .resp_err(k_resp_err), .busy(k_busy)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       exp_q[$];
  logic [7:0]  model_mem [DEPTH*4];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned last_waits = 0;
  bit          rand_rr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void zero_model();
    for (int unsigned i = 0; i < DEPTH*4; i++) model_mem[i] = 8'h00;
  endfunction

  // Little-endian byte-array memory: n = 2**size bytes starting at addr.
  function automatic resp_t model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [1:0] sz, input logic uns);
    resp_t       r;
    int unsigned n;
    logic [31:0] v;
    r = '0;
    n = 1 << sz;
    if (sz == 2'b11 || (addr % n) != 0 || (addr / 4) >= DEPTH) begin
      r.err = 1'b1;
      return r;
    end
    if (we) begin
      for (int unsigned i = 0; i < n; i++) model_mem[addr + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = model_mem[addr + i];
      if (!uns && n < 4 && v[8*n - 1])
        for (int unsigned i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      r.rdata = v;
    end
    return r;
  endfunction

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns);
    int unsigned waits = 0;
    bit          done  = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = uns;
    while (!done) begin
      if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(model(we, addr, wd, sz, uns));
        done = 1'b1;
      end else if (waits >= 200) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: req_ready low for %0d cycles, required acceptance", waits);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #2;
    end
    req_valid  = 1'b0;
    last_waits = waits;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  // Counts INIT cycles after a reset edge; response must be absent and req_ready low throughout.
  task automatic wait_init();
    int unsigned n   = 0;
    int unsigned bad = 0;
    bit          done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (busy) begin
        n++;
        if (req_ready || resp_valid) bad++;
      end else begin
        done = 1'b1;
      end
      if (n > 100) done = 1'b1;
    end
    check("init_cycles", n, DEPTH);
    check("init_quiet", bad, 0);
    @(posedge clk); #2;
  endtask

  task automatic kdrive(input logic r, input logic v, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd);
    @(posedge clk); #2;
    k_rst = r; k_req_valid = v; k_req_we = we; k_req_addr = addr; k_req_wdata = wd;
    k_req_size = SZ_WORD; k_req_unsigned = 1'b0; k_resp_ready = 1'b1;
  endtask

  // Monitor: stability while stalled, and scoreboard pop on every response handshake.
  bit          hold = 1'b0;
  logic [31:0] hold_rdata;
  logic        hold_err;
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 32'(resp_valid), 32'd1);
        check("hold_rdata", resp_rdata, hold_rdata);
        check("hold_err", 32'(resp_err), 32'(hold_err));
      end
      if (resp_valid && !resp_ready) begin
        check("ready_while_full", 32'(req_ready), 32'd0);
        hold_rdata = resp_rdata;
        hold_err   = resp_err;
      end
      hold = resp_valid && !resp_ready;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: got rdata 0x%08h err %0b, required no response",
                   resp_rdata, resp_err);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", 32'(resp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned total;
    logic [31:0] addr;
    logic [1:0]  sz;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = SZ_WORD; req_unsigned = 1'b0; resp_ready = 1'b1;
    k_rst = 1'b1; k_req_valid = 1'b0; k_req_we = 1'b0; k_req_addr = '0; k_req_wdata = '0;
    k_req_size = SZ_WORD; k_req_unsigned = 1'b0; k_resp_ready = 1'b1;

    // Reset and clear sweep.
    @(posedge clk); #2;
    rst = 1'b0;
    exp_q.delete();
    zero_model();
    wait_init();

    // Cleared top word, then sub-word loads of a stored word.
    issue(1'b0, 32'h7C, 32'h0, SZ_WORD, 1'b0);
    issue(1'b1, 32'h10, 32'h80FF_1234, SZ_WORD, 1'b0);
    for (int unsigned i = 0; i < 4; i++) issue(1'b0, 32'h10 + i, 32'h0, SZ_BYTE, 1'b0);
    issue(1'b0, 32'h12, 32'h0, SZ_HALF, 1'b1);

    // Byte merge into an existing word.
    issue(1'b1, 32'h20, 32'h1122_3344, SZ_WORD, 1'b0);
    issue(1'b1, 32'h21, 32'hFFFF_FFAB, SZ_BYTE, 1'b0);
    issue(1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0);

    // Error cases, then an untouched word.
    issue(1'b0, 32'h06, 32'h0, SZ_WORD, 1'b0);
    issue(1'b1, 32'h03, 32'h0000_BEEF, SZ_HALF, 1'b0);
    issue(1'b0, DEPTH*4, 32'h0, SZ_WORD, 1'b0);
    issue(1'b1, 32'h14, 32'h0, 2'b11, 1'b0);
    issue(1'b0, 32'h00, 32'h0, SZ_WORD, 1'b0);

    // Consumer stall, then back-to-back transfers.
    idle(1);
    resp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0);
    idle(4);
    resp_ready = 1'b1;
    total = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      issue(1'b0, 32'(i*4), 32'h0, SZ_WORD, 1'b0);
      total += last_waits;
    end
    check("b2b_stalls", total, 0);

    // Reset while a response is pending and a store is offered.
    idle(1);
    resp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0);
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0;
    req_wdata = 32'h5555_AAAA; req_size = SZ_WORD; resp_ready = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0; req_valid = 1'b0;
    exp_q.delete();
    zero_model();
    wait_init();
    issue(1'b0, 32'h00, 32'h0, SZ_WORD, 1'b0);

    // Randomized traffic with a randomly stalling consumer.
    rand_rr = 1'b1;
    for (int unsigned i = 0; i < 300; i++) begin
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom_range(0, DEPTH*4 + 15);
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      issue(1'($urandom_range(0, 1)), addr, $urandom, sz, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    rand_rr = 1'b0;
    resp_ready = 1'b1;
    idle(3);
    check("queue_drained", exp_q.size(), 0);

    // Retained contents across reset (no clear) and the dropped store on the reset edge.
    kdrive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    kdrive(1'b0, 1'b1, 1'b1, 32'h40, 32'hCAFE_BABE);
    kdrive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    kdrive(1'b1, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    kdrive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #3;
    check("keep_resp_dropped", 32'(k_resp_valid), 32'd0);
    check("keep_busy", 32'(k_busy), 32'd0);
    check("keep_ready", 32'(k_req_ready), 32'd1);
    kdrive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    kdrive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #3;
    check("keep_load_valid", 32'(k_resp_valid), 32'd1);
    check("keep_load_rdata", k_resp_rdata, 32'hCAFE_BABE);
    check("keep_load_err", 32'(k_resp_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
